// File: rtl/uart_sender_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_sender_if
// Description : Byte-write handshake and serial line of the UART sender.
//               master = byte producer, slave = uart_sender.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_sender_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       UART_TX;

  modport master (
    output tx_data, tx_start,
    input  tx_ready, tx_busy, tx_done, UART_TX
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_ready, tx_busy, tx_done, UART_TX
  );
endinterface
`default_nettype wire

// File: rtl/uart_sender.sv
`default_nettype none
// ============================================================================
// Module      : uart_sender
// Description : 8N1 UART transmitter, LSB first, with a one-byte holding
//               register in front of the shift register so a new byte can
//               be written while the current frame is on the line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sender #(
  parameter int BAUD_DIV = 5208
) (
  input  wire logic    clk,
  input  wire logic    reset,
  uart_sender_if.slave bus
);

  localparam int              C_CW = 16;
  localparam logic [C_CW-1:0] C_TC = C_CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [C_CW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_hold;
  logic            r_full;

  logic w_tc;
  logic w_accept;

  // Terminal count ends the current bit; a write is only taken while empty.
  assign w_tc     = (r_cnt == C_TC);
  assign w_accept = bus.tx_start && bus.tx_ready;

  // Frame sequencer, holding register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_full       <= 1'b0;
      bus.tx_ready <= 1'b1;
      bus.tx_busy  <= 1'b0;
      bus.tx_done  <= 1'b0;
      bus.UART_TX  <= 1'b1;
    end else begin
      bus.tx_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // Transfer a pending byte; the start bit goes out right away.
          if (r_full) begin
            r_shift      <= r_hold;
            r_full       <= 1'b0;
            bus.tx_ready <= 1'b1;
            r_cnt        <= '0;
            r_state      <= S_START;
            bus.tx_busy  <= 1'b1;
            bus.UART_TX  <= 1'b0;
          end
        end

        S_START: begin
          if (w_tc) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_state     <= S_DATA;
            bus.UART_TX <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + C_CW'(1);
          end
        end

        S_DATA: begin
          if (w_tc) begin
            r_cnt   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state     <= S_STOP;
              bus.UART_TX <= 1'b1;
            end else begin
              // Next data bit is the one that becomes shift[0] after the shift.
              bus.UART_TX <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + C_CW'(1);
          end
        end

        S_STOP: begin
          if (w_tc) begin
            r_cnt       <= '0;
            bus.tx_done <= 1'b1;
            if (r_full) begin
              // Chain straight into the next frame without an idle bit.
              r_shift      <= r_hold;
              r_full       <= 1'b0;
              bus.tx_ready <= 1'b1;
              r_state      <= S_START;
              bus.UART_TX  <= 1'b0;
            end else begin
              r_state     <= S_IDLE;
              bus.tx_busy <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + C_CW'(1);
          end
        end
      endcase

      // An accept never coincides with a transfer: transfers need a full
      // holding register, during which tx_ready is already low.
      if (w_accept) begin
        r_hold       <= bus.tx_data;
        r_full       <= 1'b1;
        bus.tx_ready <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_sender.md
UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 5208, meaning clk cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tx_data  input  8  byte to transmit; sampled only on an accepted start.
REQ-005 SHALL have port tx_start  input  1  write strobe; accepted at a rising edge where tx_ready=1.
REQ-006 SHALL have port tx_ready  output  1  1 = holding register empty, next tx_start is accepted.
REQ-007 SHALL have port tx_busy  output  1  1 = frame currently on the line (any state other than IDLE).
REQ-008 SHALL have port tx_done  output  1  one-cycle pulse when a frame's stop bit completes.
REQ-009 SHALL have port UART_TX  output  1  serial line; idle high; 8N1, LSB first.

Function
REQ-010 SHALL contain a one-byte holding register plus an 8-bit shift register; tx_ready is a registered signal equal to NOT holding_full.
REQ-011 SHALL, on an accepted tx_start, capture tx_data into holding and set holding_full; tx_start with tx_ready=0 SHALL be ignored (no overwrite, no error flag).
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 SHALL, in IDLE with holding_full=1, move holding into shift register, clear holding_full, and enter START at the next edge; UART_TX falls one clock after the edge that set holding_full.
REQ-014 SHALL drive UART_TX = 0 in START, shift[0] in DATA, 1 in STOP and IDLE; UART_TX SHALL be registered (glitch-free).
REQ-015 SHALL hold each bit for exactly BAUD_DIV clocks using a baud counter running 0..BAUD_DIV-1, cleared on every state entry.
REQ-016 SHALL, in DATA, shift right and increment a 3-bit bit index at each counter terminal count; after index 7 completes, enter STOP.
REQ-017 SHALL, at STOP terminal count, pulse tx_done for one clock and, if holding_full=1, load holding and enter START directly (no idle gap; frame-to-frame spacing exactly 10*BAUD_DIV clocks); otherwise enter IDLE.
REQ-018 SHALL, when a transfer from holding and an accept would coincide, not accept, because tx_ready is 0 in that cycle; tx_ready returns to 1 one clock after the transfer.
REQ-019 SHALL allow a new byte to be accepted during START/DATA/STOP whenever holding is empty (double buffering).
REQ-020 SHALL never change tx_data sampling, shift contents, or line level mid-bit except via reset.

Reset
REQ-021 SHALL, while reset=0, force state=IDLE, UART_TX=1, tx_ready=1, tx_busy=0, tx_done=0, holding_full=0, counters=0, asynchronously.
REQ-022 SHALL, on reset asserted mid-frame, abort the frame immediately (UART_TX=1 without completing the stop bit) and discard the held byte; no tx_done pulse.
REQ-023 SHALL, after reset release, accept tx_start on the first rising edge.

Verification
REQ-024 SHALL check reset values: reset=0 -> UART_TX=1, tx_ready=1, tx_busy=0, tx_done=0.
REQ-025 SHALL check single byte, BAUD_DIV=4: tx_data=8'h96 pulse -> line 0,0,1,1,0,1,0,0,1,1 each 4 clocks, tx_done once, 40 clocks after first low.
REQ-026 SHALL check back-to-back: write 8'h55 then 8'hA7 while busy -> second start bit immediately follows first stop bit; two tx_done pulses 40 clocks apart.
REQ-027 SHALL check overrun: third tx_start while holding full (tx_ready=0) -> byte ignored; only two frames sent, contents unchanged.
REQ-028 SHALL check abort: reset=0 during DATA of 8'hFF -> UART_TX=1 same cycle, no tx_done; after release, 8'h00 sends cleanly.
REQ-029 SHALL check default BAUD_DIV=5208: each bit width measured as 5208 clocks with a loopback receiver at the same divider recovering the transmitted bytes.
